// File: rtl/tsc_defs.sv
`default_nettype none
// ============================================================================
//  Module      : tsc_defs (package)
//  Description : Shared definitions for the TSC CPU multi-cycle control path:
//                opcode/func codes, FSM state enum, instruction classes,
//                ALU function codes and the wb_sel / pc_src encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package tsc_defs;

  // I/J-type opcodes (IR[15:12])
  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'd0;
  localparam logic [5:0] FN_SUB = 6'd1;
  localparam logic [5:0] FN_AND = 6'd2;
  localparam logic [5:0] FN_ORR = 6'd3;
  localparam logic [5:0] FN_NOT = 6'd4;
  localparam logic [5:0] FN_TCP = 6'd5;
  localparam logic [5:0] FN_SHL = 6'd6;
  localparam logic [5:0] FN_SHR = 6'd7;
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_HLT = 6'd29;

  // ALU function codes; R-type ALU ops reuse func[2:0] directly
  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_ORR = 4'd3;
  localparam logic [3:0] ALU_LHI = 4'd8;
  localparam logic [3:0] ALU_BNE = 4'd9;
  localparam logic [3:0] ALU_BEQ = 4'd10;
  localparam logic [3:0] ALU_BGZ = 4'd11;
  localparam logic [3:0] ALU_BLZ = 4'd12;

  // Write-back source select
  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;

  // PC source select
  localparam logic [1:0] PC_PLUS1  = 2'd0;
  localparam logic [1:0] PC_BRANCH = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  // Link register used by JAL/JRL
  localparam logic [1:0] LINK_REG = 2'd2;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    C_INVALID   = 4'd0,
    C_RTYPE_ALU = 4'd1,
    C_ITYPE_ALU = 4'd2,
    C_BRANCH    = 4'd3,
    C_LOAD      = 4'd4,
    C_STORE     = 4'd5,
    C_JUMP      = 4'd6,
    C_JAL       = 4'd7,
    C_JPR       = 4'd8,
    C_JRL       = 4'd9,
    C_WWD       = 4'd10,
    C_HALT      = 4'd11
  } iclass_e;

endpackage
`default_nettype wire

// File: rtl/opcode_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : opcode_decoder
//  Description : Combinational decode of opcode/func into an instruction
//                class, ALU function code and ALU B-operand select.
//  Ports       : opcode_i      IR[15:12]
//                func_i        IR[5:0]
//                iclass_o      instruction class
//                alu_op_o      ALU function code
//                alu_src_imm_o ALU B operand: 0=rt, 1=immediate
//  Revision    : 1.0 - initial release
// ============================================================================
module opcode_decoder
  import tsc_defs::*;
(
  input  logic [3:0] opcode_i,
  input  logic [5:0] func_i,
  output iclass_e    iclass_o,
  output logic [3:0] alu_op_o,
  output logic       alu_src_imm_o
);

  always_comb begin
    iclass_o      = C_INVALID;
    alu_op_o      = ALU_ADD;
    alu_src_imm_o = 1'b0;
    if (opcode_i == OP_RTYPE) begin
      case (func_i)
        FN_ADD, FN_SUB, FN_AND, FN_ORR,
        FN_NOT, FN_TCP, FN_SHL, FN_SHR: begin
          iclass_o = C_RTYPE_ALU;
          alu_op_o = {1'b0, func_i[2:0]};
        end
        FN_JPR:  iclass_o = C_JPR;
        FN_JRL:  iclass_o = C_JRL;
        FN_WWD:  iclass_o = C_WWD;
        FN_HLT:  iclass_o = C_HALT;
        default: iclass_o = C_INVALID;
      endcase
    end else begin
      case (opcode_i)
        OP_BNE: begin iclass_o = C_BRANCH; alu_op_o = ALU_BNE; end
        OP_BEQ: begin iclass_o = C_BRANCH; alu_op_o = ALU_BEQ; end
        OP_BGZ: begin iclass_o = C_BRANCH; alu_op_o = ALU_BGZ; end
        OP_BLZ: begin iclass_o = C_BRANCH; alu_op_o = ALU_BLZ; end
        OP_ADI: begin
          iclass_o = C_ITYPE_ALU; alu_op_o = ALU_ADD; alu_src_imm_o = 1'b1;
        end
        OP_ORI: begin
          iclass_o = C_ITYPE_ALU; alu_op_o = ALU_ORR; alu_src_imm_o = 1'b1;
        end
        OP_LHI: begin
          iclass_o = C_ITYPE_ALU; alu_op_o = ALU_LHI; alu_src_imm_o = 1'b1;
        end
        // Loads/stores form the address as rs + imm
        OP_LWD: begin
          iclass_o = C_LOAD; alu_op_o = ALU_ADD; alu_src_imm_o = 1'b1;
        end
        OP_SWD: begin
          iclass_o = C_STORE; alu_op_o = ALU_ADD; alu_src_imm_o = 1'b1;
        end
        OP_JMP:  iclass_o = C_JUMP;
        OP_JAL:  iclass_o = C_JAL;
        default: iclass_o = C_INVALID;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : multicycle_control
//  Description : Multi-cycle control FSM (IF/ID/EX/MEM/WB/HALT) for the
//                16-bit four-register TSC CPU. Fetches into an internal IR
//                and sequences register-file, memory, ALU and PC controls.
//  Ports       : clk, reset_n           clock, async active-low reset
//                instr, mem_ready       memory read data / completion strobe
//                bcond                  branch condition (EX)
//                read_m, write_m        memory requests
//                instruction_fetch      high in IF/ID, falls entering EX
//                read1, read2           rs / rt register addresses
//                write_reg, reg_write   destination and write enable (WB)
//                alu_op, alu_src_imm    ALU controls (EX)
//                wb_sel                 write-back source (WB)
//                pc_write, pc_src       PC load enable and source
//                out_strobe, is_halt    WWD strobe, halted flag
//                num_inst               retired-instruction counter
//  Revision    : 1.0 - initial release
// ============================================================================
module multicycle_control
  import tsc_defs::*;
#(
  parameter int WORD_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] instr,
  input  logic              mem_ready,
  input  logic              bcond,
  output logic              read_m,
  output logic              write_m,
  output logic              instruction_fetch,
  output logic [1:0]        read1,
  output logic [1:0]        read2,
  output logic [1:0]        write_reg,
  output logic              reg_write,
  output logic [3:0]        alu_op,
  output logic              alu_src_imm,
  output logic [1:0]        wb_sel,
  output logic              pc_write,
  output logic [1:0]        pc_src,
  output logic              out_strobe,
  output logic              is_halt,
  output logic [WORD_W-1:0] num_inst
);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] ir_q, ir_d;
  logic [WORD_W-1:0] num_q, num_d;

  iclass_e           dec_class;
  logic [3:0]        dec_alu_op;
  logic              dec_alu_src_imm;

  opcode_decoder u_decoder (
    .opcode_i      (ir_q[15:12]),
    .func_i        (ir_q[5:0]),
    .iclass_o      (dec_class),
    .alu_op_o      (dec_alu_op),
    .alu_src_imm_o (dec_alu_src_imm)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IF;
      ir_q    <= '0;
      num_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      num_q   <= num_d;
    end
  end

  // Register addresses come straight from IR so they are stable from the
  // first ID cycle through WB.
  assign read1    = ir_q[11:10];
  assign read2    = ir_q[9:8];
  assign num_inst = num_q;

  always_comb begin
    state_d           = state_q;
    ir_d              = ir_q;
    num_d             = num_q;
    read_m            = 1'b0;
    write_m           = 1'b0;
    instruction_fetch = 1'b0;
    write_reg         = 2'd0;
    reg_write         = 1'b0;
    alu_op            = 4'd0;
    alu_src_imm       = 1'b0;
    wb_sel            = WB_ALU;
    pc_write          = 1'b0;
    pc_src            = PC_PLUS1;
    out_strobe        = 1'b0;
    is_halt           = 1'b0;

    case (state_q)
      S_IF: begin
        read_m            = 1'b1;
        instruction_fetch = 1'b1;
        if (mem_ready) begin
          ir_d    = instr;
          state_d = S_ID;
        end
      end

      S_ID: begin
        instruction_fetch = 1'b1;
        pc_write          = 1'b1;
        pc_src            = PC_PLUS1;
        case (dec_class)
          C_HALT:    state_d = S_HALT;
          C_INVALID: state_d = S_IF;
          default:   state_d = S_EX;
        endcase
      end

      S_EX: begin
        alu_op      = dec_alu_op;
        alu_src_imm = dec_alu_src_imm;
        state_d     = S_IF;
        case (dec_class)
          C_RTYPE_ALU, C_ITYPE_ALU: state_d = S_WB;
          C_BRANCH: begin
            if (bcond) begin
              pc_write = 1'b1;
              pc_src   = PC_BRANCH;
            end
          end
          C_JUMP: begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
          end
          C_JAL: begin
            pc_write = 1'b1;
            pc_src   = PC_JUMP;
            state_d  = S_WB;
          end
          C_JPR: begin
            pc_write = 1'b1;
            pc_src   = PC_RS;
          end
          C_JRL: begin
            pc_write = 1'b1;
            pc_src   = PC_RS;
            state_d  = S_WB;
          end
          C_LOAD, C_STORE: state_d = S_MEM;
          C_WWD:           out_strobe = 1'b1;
          default:         state_d = S_IF;
        endcase
      end

      S_MEM: begin
        read_m  = (dec_class == C_LOAD);
        write_m = (dec_class == C_STORE);
        if (mem_ready) begin
          state_d = (dec_class == C_LOAD) ? S_WB : S_IF;
        end
      end

      S_WB: begin
        reg_write = 1'b1;
        state_d   = S_IF;
        case (dec_class)
          C_RTYPE_ALU: begin write_reg = ir_q[7:6]; wb_sel = WB_ALU; end
          C_LOAD:      begin write_reg = ir_q[9:8]; wb_sel = WB_MEM; end
          C_JAL, C_JRL: begin write_reg = LINK_REG; wb_sel = WB_PC; end
          default:     begin write_reg = ir_q[9:8]; wb_sel = WB_ALU; end
        endcase
      end

      S_HALT: begin
        is_halt = 1'b1;
      end

      default: state_d = S_IF;
    endcase

    // An instruction retires whenever control returns to IF from a later
    // stage, or when it parks in HALT.
    if (((state_d == S_IF) && (state_q != S_IF)) ||
        ((state_d == S_HALT) && (state_q != S_HALT))) begin
      num_d = num_q + {{(WORD_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multicycle_control
//  Description : Self-checking bench for multicycle_control. Each
//                instruction is expanded into its expected stage sequence
//                from the latency rules, and every cycle's outputs are
//                compared with values derived from the instruction fields.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  localparam int WORD_W = 16;

  localparam int K_RALU = 0;
  localparam int K_IALU = 1;
  localparam int K_BR   = 2;
  localparam int K_LWD  = 3;
  localparam int K_SWD  = 4;
  localparam int K_JMP  = 5;
  localparam int K_JAL  = 6;
  localparam int K_JPR  = 7;
  localparam int K_JRL  = 8;
  localparam int K_WWD  = 9;
  localparam int K_HLT  = 10;
  localparam int K_NOP  = 11;

  localparam int P_IF  = 0;
  localparam int P_ID  = 1;
  localparam int P_EX  = 2;
  localparam int P_MEM = 3;
  localparam int P_WB  = 4;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [WORD_W-1:0] instr;
  logic              mem_ready;
  logic              bcond;
  logic              read_m, write_m, instruction_fetch;
  logic [1:0]        read1, read2, write_reg;
  logic              reg_write;
  logic [3:0]        alu_op;
  logic              alu_src_imm;
  logic [1:0]        wb_sel;
  logic              pc_write;
  logic [1:0]        pc_src;
  logic              out_strobe, is_halt;
  logic [WORD_W-1:0] num_inst;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] model_count;
  logic [15:0] prev_ir;

  always #5 clk = ~clk;

  multicycle_control #(.WORD_W(WORD_W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .instr             (instr),
    .mem_ready         (mem_ready),
    .bcond             (bcond),
    .read_m            (read_m),
    .write_m           (write_m),
    .instruction_fetch (instruction_fetch),
    .read1             (read1),
    .read2             (read2),
    .write_reg         (write_reg),
    .reg_write         (reg_write),
    .alu_op            (alu_op),
    .alu_src_imm       (alu_src_imm),
    .wb_sel            (wb_sel),
    .pc_write          (pc_write),
    .pc_src            (pc_src),
    .out_strobe        (out_strobe),
    .is_halt           (is_halt),
    .num_inst          (num_inst)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int kind_of(input logic [15:0] ins);
    int k;
    k = K_NOP;
    if (ins[15:12] == 4'hF) begin
      if (ins[5:0] <= 6'd7)       k = K_RALU;
      else if (ins[5:0] == 6'd25) k = K_JPR;
      else if (ins[5:0] == 6'd26) k = K_JRL;
      else if (ins[5:0] == 6'd28) k = K_WWD;
      else if (ins[5:0] == 6'd29) k = K_HLT;
    end else begin
      case (ins[15:12])
        4'd0, 4'd1, 4'd2, 4'd3: k = K_BR;
        4'd4, 4'd5, 4'd6:       k = K_IALU;
        4'd7:                   k = K_LWD;
        4'd8:                   k = K_SWD;
        4'd9:                   k = K_JMP;
        4'd10:                  k = K_JAL;
        default:                k = K_NOP;
      endcase
    end
    return k;
  endfunction

  // ALU function table: R-type ops use their func number, immediate ops
  // use the matching R-type op (ORI->ORR), LHI=8, branches BNE..BLZ=9..12.
  function automatic logic [3:0] exp_alu(input logic [15:0] ins);
    logic [3:0] a;
    a = 4'd0;
    if (ins[15:12] == 4'hF) a = {1'b0, ins[2:0]};
    else begin
      case (ins[15:12])
        4'd0: a = 4'd9;
        4'd1: a = 4'd10;
        4'd2: a = 4'd11;
        4'd3: a = 4'd12;
        4'd5: a = 4'd3;
        4'd6: a = 4'd8;
        default: a = 4'd0;
      endcase
    end
    return a;
  endfunction

  task automatic check_reset_vals(input string pfx);
    chk({pfx, ".read_m"},      32'(read_m), 32'd1);
    chk({pfx, ".ifetch"},      32'(instruction_fetch), 32'd1);
    chk({pfx, ".write_m"},     32'(write_m), 32'd0);
    chk({pfx, ".reg_write"},   32'(reg_write), 32'd0);
    chk({pfx, ".pc_write"},    32'(pc_write), 32'd0);
    chk({pfx, ".out_strobe"},  32'(out_strobe), 32'd0);
    chk({pfx, ".is_halt"},     32'(is_halt), 32'd0);
    chk({pfx, ".num_inst"},    32'(num_inst), 32'd0);
    chk({pfx, ".read1"},       32'(read1), 32'd0);
    chk({pfx, ".read2"},       32'(read2), 32'd0);
    chk({pfx, ".write_reg"},   32'(write_reg), 32'd0);
    chk({pfx, ".wb_sel"},      32'(wb_sel), 32'd0);
    chk({pfx, ".pc_src"},      32'(pc_src), 32'd0);
    chk({pfx, ".alu_op"},      32'(alu_op), 32'd0);
    chk({pfx, ".alu_src_imm"}, 32'(alu_src_imm), 32'd0);
  endtask

  task automatic cycle_check(input int ph, input logic [15:0] ins, input bit bc, input int k);
    string       pn;
    logic [15:0] vis_ir;
    bit          e_pcw;
    logic [1:0]  e_src;
    bit          jumpy;
    pn     = (ph == P_IF) ? "IF" : (ph == P_ID) ? "ID" : (ph == P_EX) ? "EX" :
             (ph == P_MEM) ? "MEM" : "WB";
    vis_ir = (ph == P_IF) ? prev_ir : ins;
    jumpy  = (k == K_JMP) || (k == K_JAL) || (k == K_JPR) || (k == K_JRL);
    e_pcw  = (ph == P_ID) || ((ph == P_EX) && (((k == K_BR) && bc) || jumpy));

    chk({pn, ".read_m"},     32'(read_m), 32'((ph == P_IF) || ((ph == P_MEM) && (k == K_LWD))));
    chk({pn, ".write_m"},    32'(write_m), 32'((ph == P_MEM) && (k == K_SWD)));
    chk({pn, ".ifetch"},     32'(instruction_fetch), 32'((ph == P_IF) || (ph == P_ID)));
    chk({pn, ".reg_write"},  32'(reg_write), 32'(ph == P_WB));
    chk({pn, ".pc_write"},   32'(pc_write), 32'(e_pcw));
    chk({pn, ".out_strobe"}, 32'(out_strobe), 32'((ph == P_EX) && (k == K_WWD)));
    chk({pn, ".is_halt"},    32'(is_halt), 32'd0);
    chk({pn, ".num_inst"},   32'(num_inst), 32'(model_count));
    chk({pn, ".read1"},      32'(read1), 32'(vis_ir[11:10]));
    chk({pn, ".read2"},      32'(read2), 32'(vis_ir[9:8]));

    if (e_pcw) begin
      if (ph == P_ID)                         e_src = 2'd0;
      else if (k == K_BR)                     e_src = 2'd1;
      else if ((k == K_JMP) || (k == K_JAL))  e_src = 2'd2;
      else                                    e_src = 2'd3;
      chk({pn, ".pc_src"}, 32'(pc_src), 32'(e_src));
    end
    if (ph == P_WB) begin
      if (k == K_RALU) begin
        chk("WB.write_reg", 32'(write_reg), 32'(ins[7:6]));
        chk("WB.wb_sel",    32'(wb_sel), 32'd0);
      end else if ((k == K_JAL) || (k == K_JRL)) begin
        chk("WB.write_reg", 32'(write_reg), 32'd2);
        chk("WB.wb_sel",    32'(wb_sel), 32'd2);
      end else begin
        chk("WB.write_reg", 32'(write_reg), 32'(ins[9:8]));
        chk("WB.wb_sel",    32'(wb_sel), (k == K_LWD) ? 32'd1 : 32'd0);
      end
    end
    if ((ph == P_EX) && ((k == K_RALU) || (k == K_IALU) || (k == K_BR) ||
                         (k == K_LWD) || (k == K_SWD))) begin
      chk("EX.alu_op",      32'(alu_op), 32'(exp_alu(ins)));
      chk("EX.alu_src_imm", 32'(alu_src_imm),
          32'((k == K_IALU) || (k == K_LWD) || (k == K_SWD)));
    end
  endtask

  // Runs one instruction starting in its first IF cycle (just after a rising
  // edge). n_if / m_mem are the wait cycles before mem_ready in IF / MEM.
  task automatic run_instr(input logic [15:0] ins, input int n_if, input int m_mem,
                           input bit bc, input bit abort);
    int k;
    int ph[$];
    int last_if;
    int last_mem;
    k        = kind_of(ins);
    last_mem = -1;
    for (int i = 0; i <= n_if; i++) ph.push_back(P_IF);
    last_if = n_if;
    ph.push_back(P_ID);
    if ((k != K_HLT) && (k != K_NOP)) begin
      ph.push_back(P_EX);
      if ((k == K_LWD) || (k == K_SWD)) begin
        for (int i = 0; i <= m_mem; i++) ph.push_back(P_MEM);
        last_mem = ph.size() - 1;
      end
      if ((k == K_RALU) || (k == K_IALU) || (k == K_LWD) || (k == K_JAL) || (k == K_JRL))
        ph.push_back(P_WB);
    end

    for (int i = 0; i < ph.size(); i++) begin
      instr = (i == last_if) ? ins : 16'($urandom);
      if (ph[i] == P_IF)       mem_ready = (i == last_if);
      else if (ph[i] == P_MEM) mem_ready = (i == last_mem);
      else                     mem_ready = 1'($urandom_range(0, 1));
      bcond = (ph[i] == P_EX) ? bc : 1'($urandom_range(0, 1));

      if (abort && (ph[i] == P_MEM)) begin
        mem_ready = 1'b0;
        #1;
        chk("abort.pre_write_m", 32'(write_m), 32'd1);
        reset_n = 1'b0;
        #1;
        check_reset_vals("abort");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        model_count = 16'd0;
        prev_ir     = 16'd0;
        return;
      end

      @(negedge clk);
      cycle_check(ph[i], ins, bc, k);
      @(posedge clk);
      #1;
    end
    prev_ir     = ins;
    model_count = model_count + 16'd1;
  endtask

  function automatic logic [15:0] gen_instr();
    logic [15:0] r;
    int          sel;
    r   = 16'($urandom);
    sel = $urandom_range(0, 11);
    case (sel)
      0:  begin r[15:12] = 4'hF; r[5:0] = 6'($urandom_range(0, 7)); end
      1:  r[15:12] = 4'($urandom_range(0, 3));
      2:  r[15:12] = 4'($urandom_range(4, 6));
      3:  r[15:12] = 4'd7;
      4:  r[15:12] = 4'd8;
      5:  r[15:12] = 4'd9;
      6:  r[15:12] = 4'd10;
      7:  begin r[15:12] = 4'hF; r[5:0] = 6'd25; end
      8:  begin r[15:12] = 4'hF; r[5:0] = 6'd26; end
      9:  begin r[15:12] = 4'hF; r[5:0] = 6'd28; end
      10: r[15:12] = 4'($urandom_range(11, 14));
      default: begin r[15:12] = 4'hF; r[5:0] = 6'($urandom_range(30, 63)); end
    endcase
    return r;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    instr       = 16'hFFFF;
    mem_ready   = 1'b0;
    bcond       = 1'b0;
    model_count = 16'd0;
    prev_ir     = 16'd0;
    #3;
    check_reset_vals("por");
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    run_instr(16'h4503, 0, 0, 1'b0, 1'b0);  // ADI rt=1 imm=3
    run_instr(16'hF180, 1, 0, 1'b0, 1'b0);  // ADD rd=2, rs=0, rt=1
    run_instr(16'h7602, 0, 3, 1'b0, 1'b0);  // LWD rt=2, MEM waits 3
    run_instr(16'h1123, 2, 0, 1'b1, 1'b0);  // BEQ taken
    run_instr(16'h1123, 0, 0, 1'b0, 1'b0);  // BEQ not taken
    run_instr(16'hA00F, 0, 0, 1'b0, 1'b0);  // JAL
    run_instr(16'hF41C, 0, 0, 1'b0, 1'b0);  // WWD
    run_instr(16'hB000, 0, 0, 1'b0, 1'b0);  // undefined opcode -> NOP
    run_instr(16'h8A05, 1, 2, 1'b0, 1'b0);  // SWD

    // Randomized stream
    for (int n = 0; n < 300; n++) begin
      run_instr(gen_instr(), $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset during MEM of a store
    run_instr(16'h8A05, 0, 3, 1'b0, 1'b1);
    run_instr(16'h4503, 0, 0, 1'b0, 1'b0);

    // HLT, then HALT must absorb memory strobes
    run_instr(16'hF01D, 1, 0, 1'b0, 1'b0);
    for (int j = 0; j < 8; j++) begin
      instr     = 16'($urandom);
      mem_ready = 1'(j % 2);
      bcond     = 1'($urandom_range(0, 1));
      @(negedge clk);
      chk("HALT.is_halt",    32'(is_halt), 32'd1);
      chk("HALT.read_m",     32'(read_m), 32'd0);
      chk("HALT.write_m",    32'(write_m), 32'd0);
      chk("HALT.ifetch",     32'(instruction_fetch), 32'd0);
      chk("HALT.reg_write",  32'(reg_write), 32'd0);
      chk("HALT.pc_write",   32'(pc_write), 32'd0);
      chk("HALT.out_strobe", 32'(out_strobe), 32'd0);
      chk("HALT.num_inst",   32'(num_inst), 32'(model_count));
      @(posedge clk);
      #1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle control FSM for the 16-bit, four-register TSC CPU. It is the initiator side of the register-file interface. It fetches an instruction through a ready-handshake memory port and latches it into an internal instruction register (IR). It then drives `read1`, `read2`, `instruction_fetch`, `write_reg` and `reg_write` so that operands are sampled and results are written on the register file's schedule, and it also steers the datapath muxes and the PC.

## Interface
Parameters:
- `WORD_W`, 16, instruction/word width (IR width, `num_inst` width)

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `instr`  in  16  memory read data, latched into IR in IF when `mem_ready`=1
- `mem_ready`  in  1  one-cycle memory completion strobe; ignored outside IF/MEM
- `bcond`  in  1  branch condition from ALU, valid in EX
- `read_m`  out  1  memory read request (IF; MEM for LWD)
- `write_m`  out  1  memory write request (MEM for SWD)
- `instruction_fetch`  out  1  high in IF and ID; its falling edge triggers register-file operand sampling
- `read1`  out  2  IR[11:10] (rs)
- `read2`  out  2  IR[9:8] (rt)
- `write_reg`  out  2  destination register, valid while `reg_write`=1
- `reg_write`  out  1  register write enable, high only in WB
- `alu_op`  out  4  ALU function code, valid in EX
- `alu_src_imm`  out  1  ALU B operand: 0=rt, 1=immediate
- `wb_sel`  out  2  write-back source: 0=ALU, 1=memory, 2=PC
- `pc_write`  out  1  PC load enable
- `pc_src`  out  2  PC source: 0=PC+1, 1=branch target, 2=jump target, 3=rs
- `out_strobe`  out  1  WWD output-port strobe, one cycle
- `is_halt`  out  1  high in HALT
- `num_inst`  out  WORD_W  retired-instruction counter

## Operation
- IR field decode: opcode IR[15:12], rs IR[11:10], rt IR[9:8], rd IR[7:6], func IR[5:0], imm IR[7:0], target IR[11:0].
- Opcode 15 is R-type, decoded by func: ADD 0, SUB 1, AND 2, ORR 3, NOT 4, TCP 5, SHL 6, SHR 7, JPR 25, JRL 26, WWD 28, HLT 29.
- I/J-type opcodes: BNE 0, BEQ 1, BGZ 2, BLZ 3, ADI 4, ORI 5, LHI 6, LWD 7, SWD 8, JMP 9, JAL 10.
- States are IF, ID, EX, MEM, WB, HALT.
- IF:
  - `read_m`=1.
  - Stays in IF until `mem_ready`; then IR <= `instr` and the FSM goes to ID.
- ID (1 cycle):
  - `pc_write`=1 with `pc_src`=0.
  - HLT goes to HALT.
  - Undefined opcode or func is a NOP: goes to IF and retires.
  - All other instructions go to EX.
- EX (1 cycle):
  - ALU and immediate ops go to WB.
  - Branch: if `bcond`=1, `pc_write`=1 with `pc_src`=1. Then goes to IF.
  - JMP: `pc_src`=2, then IF. JAL: `pc_src`=2, then WB.
  - JPR: `pc_src`=3, then IF. JRL: `pc_src`=3, then WB.
  - LWD and SWD go to MEM.
  - WWD: `out_strobe`=1, then IF.
- MEM:
  - `read_m`=1 for LWD, `write_m`=1 for SWD.
  - Waits for `mem_ready`; then LWD goes to WB and SWD goes to IF.
- WB (1 cycle), then IF:
  - `reg_write`=1.
  - R-type: `write_reg`=rd, `wb_sel`=0.
  - ADI/ORI/LHI: `write_reg`=rt, `wb_sel`=0.
  - LWD: `write_reg`=rt, `wb_sel`=1.
  - JAL/JRL: `write_reg`=2, `wb_sel`=2.
- HALT: absorbing until reset. All strobes are 0 and `is_halt`=1.
- `num_inst` increments by 1 on every transition into IF from ID/EX/MEM/WB, and on entry to HALT. It wraps from 0xFFFF to 0.

## Timing
- Every output except `num_inst` is combinational from state and IR.
- Reset is asynchronous and takes effect immediately:
  - state=IF, IR=0, `num_inst`=0.
  - `read_m`=1 and `instruction_fetch`=1; all other outputs are 0.
  - `read1`/`read2`=0.
- Reset mid-operation abandons the instruction and issues no write.
- `read1`/`read2` are stable from the first ID cycle. `instruction_fetch` falls on the ID→EX edge, so operands are sampled with a valid IR.
- Instruction latencies in cycles, with N = IF memory wait cycles and M = MEM wait cycles:
  - ALU/immediate ops: N+1 (IF) + 1 (ID) + 1 (EX) + 1 (WB).
  - Branch, JMP, JPR, WWD: IF + ID + EX.
  - LWD: IF + ID + EX + (M+1) + WB.
  - SWD: IF + ID + EX + (M+1).
- `mem_ready` arriving in the same cycle IF is entered is accepted, giving a minimum IF of 1 cycle.
- `reg_write`, `pc_write` and `out_strobe` never exceed one cycle per state visit.

## Structure
- Package `tsc_defs`: opcode and func constants, state enum, `wb_sel`/`pc_src` encodings.
- Sub-module `opcode_decoder`: combinational IR → instruction class (rtype_alu, itype_alu, branch, load, store, jump, jal, jpr, jrl, wwd, halt, invalid), `alu_op`, `alu_src_imm`.

## Test plan
- Reset, then ADI with IR=0x4503 (rt=1, imm=3) and `mem_ready` immediate:
  - IF→ID→EX→WB.
  - `reg_write`=1 for one cycle with `write_reg`=1.
  - `num_inst`=1.
- R-type ADD 0xF180 (rd=2): `instruction_fetch` falls entering EX with `read1`=0 and `read2`=1; WB has `write_reg`=2.
- LWD 0x7602 with MEM `mem_ready` delayed 3 cycles: `read_m` is high for 4 MEM cycles, then WB with `wb_sel`=1 and `write_reg`=2.
- BEQ with `bcond`=1 gives a `pc_write` pulse in ID (`pc_src`=0) and in EX (`pc_src`=1). With `bcond`=0 there is only the ID pulse.
- HLT 0xF01D: enters HALT, `is_halt`=1, `num_inst` increments once, and further `mem_ready` pulses are ignored.
- `reset_n` asserted low during MEM of SWD: outputs immediately return to reset values, `write_m`=0, `num_inst`=0.
